// File: rtl/mem_copy_engine.sv
// Block-move engine: copies `length` words src->dst, one READ then one WRITE cycle per word.
// Optional running checksum output enabled by defining MEM_COPY_CHECKSUM_EN.
module mem_copy_engine #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [ADDR_W-1:0] dst_base,
  input  logic [ADDR_W-1:0] length,
  input  logic [DATA_W-1:0] readData,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_write_en,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] words_copied
`ifdef MEM_COPY_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] checksum
`endif
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] src_ptr, src_ptr_n;
  logic [ADDR_W-1:0] dst_ptr, dst_ptr_n;
  logic [ADDR_W-1:0] remaining, remaining_n;
  logic [ADDR_W-1:0] words_n;
  logic [ADDR_W-1:0] address_n;
  logic [DATA_W-1:0] wdata_n;
  logic              wen_n;

  // mem_write_data doubles as the read buffer: it is loaded at the end of READ
  // and presented unchanged throughout the following WRITE cycle.
  always_comb begin
    state_n     = state;
    src_ptr_n   = src_ptr;
    dst_ptr_n   = dst_ptr;
    remaining_n = remaining;
    words_n     = words_copied;
    address_n   = address;
    wdata_n     = mem_write_data;
    wen_n       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          words_n = '0;
          if (length != '0) begin
            src_ptr_n   = src_base;
            dst_ptr_n   = dst_base;
            remaining_n = length;
            address_n   = src_base;
            state_n     = READ;
          end else begin
            state_n = DONE;
          end
        end
      end
      READ: begin
        wdata_n   = readData;
        address_n = dst_ptr;
        wen_n     = 1'b1;
        state_n   = WRITE;
      end
      WRITE: begin
        src_ptr_n   = src_ptr + ADDR_W'(1);
        dst_ptr_n   = dst_ptr + ADDR_W'(1);
        remaining_n = remaining - ADDR_W'(1);
        words_n     = words_copied + ADDR_W'(1);
        if (remaining == ADDR_W'(1)) begin
          state_n = DONE;
        end else begin
          address_n = src_ptr + ADDR_W'(1);
          state_n   = READ;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      src_ptr        <= '0;
      dst_ptr        <= '0;
      remaining      <= '0;
      words_copied   <= '0;
      address        <= '0;
      mem_write_data <= '0;
      mem_write_en   <= 1'b0;
    end else begin
      state          <= state_n;
      src_ptr        <= src_ptr_n;
      dst_ptr        <= dst_ptr_n;
      remaining      <= remaining_n;
      words_copied   <= words_n;
      address        <= address_n;
      mem_write_data <= wdata_n;
      mem_write_en   <= wen_n;
    end
  end

  assign busy = (state == READ) || (state == WRITE);
  assign done = (state == DONE);

`ifdef MEM_COPY_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      checksum <= '0;
    end else if (state == IDLE && start) begin
      checksum <= '0;
    end else if (state == WRITE) begin
      checksum <= checksum + mem_write_data;
    end
  end
`endif

endmodule
